// File: rtl/jedro_1_uart_tx_if.sv
// Data-bus bundle between the jedro_1 core (initiator) and bus responders.
`timescale 1ns/1ps
interface jedro_1_uart_tx_if;
    logic        stb;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output stb, we, addr, wdata, input rdata, ack, err);
    modport slave  (input stb, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/jedro_1_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the jedro_1 data bus.
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte in the FIFO
//   S_START | start bit (low) for one bit period
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (high); chains straight into the next frame if data waits
`timescale 1ns/1ps
module jedro_1_uart_tx #(
    parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [15:0] CLK_DIV_DEFAULT = 16'd868
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    jedro_1_uart_tx_if.slave bus,
    output logic             tx_o
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    state_t state, state_nxt;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, busy;

    logic [15:0] divisor, div_eff;
    logic [15:0] bit_len, bit_len_nxt, cyc_cnt, cyc_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;

    logic        hit, aligned, is_wr, div_wr;
    logic [1:0]  reg_sel;
    logic        resp_ack, resp_err;
    logic [31:0] resp_rdata, status;
    logic        unused_wdata_hi;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign busy    = (state != S_IDLE);
    assign div_eff = (divisor == 16'd0) ? 16'd1 : divisor;
    assign status  = {23'h0, 5'(count), 1'b0, busy, empty, full};

    assign hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign aligned = (bus.addr[1:0] == 2'b00);
    assign reg_sel = bus.addr[3:2];
    assign is_wr   = |bus.we;
    assign div_wr  = bus.stb && hit && aligned && (reg_sel == 2'd2) && is_wr;
    assign unused_wdata_hi = ^bus.wdata[31:16];

    always_comb begin
        resp_ack   = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        push       = 1'b0;
        if (bus.stb) begin
            if (!hit || !aligned) begin
                resp_err = 1'b1;
            end else begin
                case (reg_sel)
                    2'd0: begin
                        // Full is taken from the registered count; a same-cycle pop does not help.
                        if (is_wr && bus.we[0]) begin
                            if (full) begin
                                resp_err = 1'b1;
                            end else begin
                                resp_ack = 1'b1;
                                push     = 1'b1;
                            end
                        end else begin
                            resp_ack = 1'b1;
                        end
                    end
                    2'd1: begin
                        if (is_wr) begin
                            resp_err = 1'b1;
                        end else begin
                            resp_ack   = 1'b1;
                            resp_rdata = status;
                        end
                    end
                    2'd2: begin
                        resp_ack = 1'b1;
                        if (!is_wr) resp_rdata = {16'h0, divisor};
                    end
                    default: resp_err = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
            divisor   <= CLK_DIV_DEFAULT;
        end else begin
            bus.ack   <= resp_ack;
            bus.err   <= resp_err;
            bus.rdata <= resp_rdata;
            if (div_wr && bus.we[0]) divisor[7:0]  <= bus.wdata[7:0];
            if (div_wr && bus.we[1]) divisor[15:8] <= bus.wdata[15:8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        bit_len_nxt = bit_len;
        cyc_cnt_nxt = cyc_cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    shreg_nxt   = fifo_mem[rd_ptr];
                    bit_len_nxt = div_eff;
                    cyc_cnt_nxt = div_eff - 16'd1;
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = S_START;
                end
            end
            S_START: begin
                if (cyc_cnt == 16'd0) begin
                    cyc_cnt_nxt = bit_len - 16'd1;
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = S_DATA;
                end else begin
                    cyc_cnt_nxt = cyc_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (cyc_cnt == 16'd0) begin
                    cyc_cnt_nxt = bit_len - 16'd1;
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd7) state_nxt = S_STOP;
                    else                 bit_cnt_nxt = bit_cnt + 3'd1;
                end else begin
                    cyc_cnt_nxt = cyc_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (cyc_cnt == 16'd0) begin
                    bit_cnt_nxt = 3'd0;
                    if (!empty) begin
                        // Back-to-back frame: no idle gap, new divisor latched here.
                        pop         = 1'b1;
                        shreg_nxt   = fifo_mem[rd_ptr];
                        bit_len_nxt = div_eff;
                        cyc_cnt_nxt = div_eff - 16'd1;
                        state_nxt   = S_START;
                    end else begin
                        state_nxt   = S_IDLE;
                    end
                end else begin
                    cyc_cnt_nxt = cyc_cnt - 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_len <= '0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            bit_len <= bit_len_nxt;
            cyc_cnt <= cyc_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        case (state)
            S_START: tx_o = 1'b0;
            S_DATA:  tx_o = shreg[0];
            default: tx_o = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_jedro_1_uart_tx.sv
// Self-checking bench for jedro_1_uart_tx: bus decode model, line waveform and UART receiver.
`timescale 1ns/1ps
module tb_jedro_1_uart_tx;
    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam int          DEPTH   = 4;
    localparam logic [15:0] DIV_RST = 16'd868;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic tx;

    jedro_1_uart_tx_if bus_if();

    jedro_1_uart_tx #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLK_DIV_DEFAULT(DIV_RST)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .bus(bus_if), .tx_o(tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: divisor register and bytes accepted into the FIFO.
    logic [15:0] m_div = DIV_RST;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic        exp_wave[$];

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        full;
        logic [31:0] status;
    } req_t;
    req_t rq[$];

    task automatic add(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic full, input logic [31:0] status);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.full = full; r.status = status;
        rq.push_back(r);
    endtask

    task automatic model_resp(input req_t r, output logic e_ack, output logic e_err,
                              output logic [31:0] e_rd);
        logic [31:0] off;
        off   = r.addr - BASE;
        e_ack = 1'b0; e_err = 1'b0; e_rd = 32'h0;
        if (r.addr < BASE || r.addr >= BASE + 32'd16 || (r.addr % 4) != 0) begin
            e_err = 1'b1;
        end else if (off == 0) begin
            if (r.we[0]) begin
                if (r.full) e_err = 1'b1;
                else begin e_ack = 1'b1; exp_q.push_back(r.wdata[7:0]); end
            end else begin
                e_ack = 1'b1;
            end
        end else if (off == 4) begin
            if (r.we != 0) e_err = 1'b1;
            else begin e_ack = 1'b1; e_rd = r.status; end
        end else if (off == 8) begin
            e_ack = 1'b1;
            if (r.we == 0) e_rd = {16'h0, m_div};
            else begin
                if (r.we[0]) m_div[7:0]  = r.wdata[7:0];
                if (r.we[1]) m_div[15:8] = r.wdata[15:8];
            end
        end else begin
            e_err = 1'b1;
        end
    endtask

    // Issues queued requests on consecutive cycles; each response is checked one cycle later.
    task automatic run_burst();
        int n;
        logic ea, ee;
        logic [31:0] er;
        n = rq.size();
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                model_resp(rq[i-1], ea, ee, er);
                check("ack",   32'(bus_if.ack), 32'(ea));
                check("err",   32'(bus_if.err), 32'(ee));
                check("rdata", bus_if.rdata,    er);
            end
            if (i < n) begin
                bus_if.stb = 1'b1; bus_if.we = rq[i].we;
                bus_if.addr = rq[i].addr; bus_if.wdata = rq[i].wdata;
            end else begin
                bus_if.stb = 1'b0; bus_if.we = 4'h0;
            end
        end
        rq.delete();
    endtask

    task automatic add_frame(input logic [7:0] b, input int n);
        for (int bi = 0; bi < 10; bi++)
            for (int c = 0; c < n; c++)
                exp_wave.push_back(bi == 0 ? 1'b0 : (bi == 9 ? 1'b1 : b[bi-1]));
    endtask

    task automatic watch_line();
        int len;
        len = exp_wave.size();
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            check("tx_wave", 32'(tx), 32'(exp_wave[c]));
        end
        exp_wave.delete();
    endtask

    // Independent UART receiver sampling mid-bit on the falling clock edge.
    int rx_div = 1;
    bit rx_en  = 1'b0;
    initial begin
        logic [7:0] b;
        int n;
        b = 8'h0;
        forever begin
            @(negedge clk);
            if (rx_en && rstn && tx === 1'b0) begin
                n = rx_div;
                repeat (n + n / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    b[k] = tx;
                    if (k < 7) repeat (n) @(negedge clk);
                end
                repeat (n) @(negedge clk);
                check("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    task automatic drain_and_compare();
        int c;
        logic [7:0] got, exp;
        c = 0;
        while (rx_q.size() < exp_q.size() && c < 3000) begin
            @(posedge clk); c++;
        end
        check("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            got = rx_q.pop_front();
            exp = exp_q.pop_front();
            check("rx_byte", 32'(got), 32'(exp));
        end
        exp_q.delete();
        rx_q.delete();
        repeat (2 * rx_div + 4) @(posedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, k, dsel;
        logic [15:0] dv;
        logic [31:0] a;
        bus_if.stb = 1'b0; bus_if.we = 4'h0; bus_if.addr = '0; bus_if.wdata = '0;

        repeat (3) @(posedge clk); #1;
        check("rst_tx",    32'(tx),         32'd1);
        check("rst_ack",   32'(bus_if.ack), 32'd0);
        check("rst_err",   32'(bus_if.err), 32'd0);
        check("rst_rdata", bus_if.rdata,    32'd0);
        rstn = 1'b1;

        add(4'h0, BASE + 4, 0, 0, 32'h2);
        run_burst();
        check("idle_tx", 32'(tx), 32'd1);

        // Divisor lanes, then a single 0x55 frame with a mid-frame STATUS read.
        add(4'h3, BASE + 8, 32'hABCD_0004, 0, 0);
        add(4'h2, BASE + 8, 32'h0000_1200, 0, 0);
        add(4'h0, BASE + 8, 0, 0, 0);
        add(4'h3, BASE + 8, 32'h0000_0004, 0, 0);
        add(4'h0, BASE + 8, 0, 0, 0);
        run_burst();
        rx_div = 4; rx_en = 1'b1;
        add(4'h1, BASE, 32'h55, 0, 0);
        run_burst();
        add_frame(8'h55, 4);
        fork
            watch_line();
            begin
                repeat (9) @(posedge clk);
                add(4'h0, BASE + 4, 0, 0, 32'h6);
                run_burst();
            end
        join
        drain_and_compare();
        add(4'h0, BASE + 4, 0, 0, 32'h2);
        run_burst();

        // Fill the FIFO behind a running frame, then overflow it.
        add(4'h1, BASE, 32'h80, 0, 0);
        for (int i = 1; i <= 4; i++) add(4'h1, BASE, 32'(i), 0, 0);
        add(4'h0, BASE + 4, 0, 0, 32'h45);
        add(4'h1, BASE, 32'h05, 1, 0);
        run_burst();
        drain_and_compare();

        // Decode errors and no-effect accesses; count must stay zero.
        add(4'h0, BASE + 12, 0, 0, 0);
        add(4'hF, BASE + 4, 32'hFFFF_FFFF, 0, 0);
        add(4'h0, BASE + 2, 0, 0, 0);
        add(4'h0, BASE + 16, 0, 0, 0);
        add(4'h2, BASE, 32'h77, 0, 0);
        add(4'h0, BASE, 0, 0, 0);
        add(4'h0, BASE + 4, 0, 0, 32'h2);
        run_burst();

        // Two contiguous frames at divisor 2.
        add(4'h1, BASE + 8, 32'h2, 0, 0);
        run_burst();
        rx_div = 2;
        add(4'h1, BASE, 32'hA5, 0, 0);
        run_burst();
        add_frame(8'hA5, 2);
        add_frame(8'h3C, 2);
        fork
            watch_line();
            begin
                add(4'h1, BASE, 32'h3C, 0, 0);
                run_burst();
            end
        join
        add(4'h0, BASE + 4, 0, 0, 32'h2);
        run_burst();
        drain_and_compare();

        // Randomized divisors, bytes and interleaved bad accesses.
        for (int it = 0; it < 8; it++) begin
            dsel = int'($urandom_range(0, 4));
            dv = 16'(dsel);
            add(4'h3, BASE + 8, {16'($urandom()), dv}, 0, 0);
            run_burst();
            rx_div = (dv == 0) ? 1 : int'(dv);
            k = int'($urandom_range(1, DEPTH));
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       a = BASE + 32'd12;
                        1:       a = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
                        default: a = BASE + 32'(16 * $urandom_range(1, 100));
                    endcase
                    add(4'($urandom()), a, $urandom(), 0, 0);
                end
                add(4'h1 | (4'($urandom()) & 4'hE), BASE, $urandom(), 0, 0);
            end
            run_burst();
            drain_and_compare();
            add(4'h0, BASE + 4, 0, 0, 32'h2);
            run_burst();
        end

        // Asynchronous reset in the middle of a frame.
        add(4'h1, BASE + 8, 32'h4, 0, 0);
        run_burst();
        rx_en = 1'b0;
        add(4'h1, BASE, 32'h00, 0, 0);
        add(4'h1, BASE, 32'h11, 0, 0);
        add(4'h1, BASE, 32'h22, 0, 0);
        run_burst();
        repeat (8) @(posedge clk);
        #3;
        bus_if.stb = 1'b1; bus_if.we = 4'h0; bus_if.addr = BASE + 4;
        rstn = 1'b0;
        #1;
        check("rst_async_tx", 32'(tx), 32'd1);
        @(posedge clk); #1;
        check("rst_pend_ack", 32'(bus_if.ack), 32'd0);
        check("rst_pend_err", 32'(bus_if.err), 32'd0);
        bus_if.stb = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        m_div = DIV_RST;
        add(4'h0, BASE + 4, 0, 0, 32'h2);
        add(4'h0, BASE + 8, 0, 0, 0);
        run_burst();
        lows = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) lows++;
        end
        check("no_frames_after_rst", 32'(lows), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
